// File: rtl/vgafill_if.sv
// Command and video-memory port bundle of the rectangle-fill engine.
// The fill engine takes the master view. The CPU register block and the memory take the slave view.
// No storage. The engine never stalls the CPU: starts that arrive while it is busy are dropped.
interface vgafill_if;
    logic [9:0]  cmd_x;
    logic [8:0]  cmd_y;
    logic [9:0]  cmd_w;
    logic [8:0]  cmd_h;
    logic [3:0]  cmd_colour;
    logic        cmd_start;
    logic        busy;
    logic        done;
    logic [19:0] vmem_addr;
    logic        vmem_re;
    logic [7:0]  vmem_rdata;
    logic        vmem_we;
    logic [7:0]  vmem_wdata;

    modport master (
        input  cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour, cmd_start, vmem_rdata,
        output busy, done, vmem_addr, vmem_re, vmem_we, vmem_wdata
    );

    modport slave (
        output cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour, cmd_start, vmem_rdata,
        input  busy, done, vmem_addr, vmem_re, vmem_we, vmem_wdata
    );
endinterface

// File: rtl/vgafill.sv
// Fills a rectangle in the 4-bit packed framebuffer. Edge bytes are read-modify-written.
// Latency: SETUP + per row (ROW + 1 per full byte + 3 per edge byte) + DONE. An empty command takes 2 cycles.
// Backpressure: none. A cmd_start while busy or in DONE is dropped. The memory port never stalls.
module vgafill #(
    parameter int HRES = 640,
    parameter int VRES = 480,
    parameter int BPL  = 320
) (
    input  logic      clk,
    input  logic      rst,
    vgafill_if.master bus
);
    localparam logic [10:0] HRES_W = 11'(HRES);
    localparam logic [9:0]  VRES_W = 10'(VRES);
    localparam logic [19:0] BPL_W  = 20'(BPL);

    typedef enum logic [2:0] {IDLE, SETUP, ROW, FULL, RD, RWAIT, MERGE, DONE} state_t;
    state_t state, state_nx;

    logic [9:0]  x_q, w_q;
    logic [8:0]  y_q, h_q;
    logic [3:0]  c_q;
    logic [10:0] x_end, x_end_nx, cur_x, cur_x_nx, x_sum;
    logic [9:0]  y_end, y_end_nx, cur_y, cur_y_nx, y_sum;
    logic [19:0] row_base, row_base_nx, cur_addr, addr_r, addr_nx;
    logic [7:0]  wdata_r, wdata_nx;
    logic        we_r, we_nx, re_r, re_nx, busy_r, done_r;
    logic        latch, advance, empty;

    assign x_sum    = {1'b0, x_q} + {1'b0, w_q};
    assign y_sum    = {1'b0, y_q} + {1'b0, h_q};
    assign empty    = (w_q == '0) || (h_q == '0) || ({1'b0, x_q} >= HRES_W) || ({1'b0, y_q} >= VRES_W);
    assign cur_addr = row_base + 20'(cur_x[10:1]);

    // A whole byte can be written blind only if it starts on an even pixel and both pixels are inside the rectangle.
    function automatic state_t step_state(logic [10:0] x, logic [10:0] xe);
        return (!x[0] && ((xe - x) >= 11'd2)) ? FULL : RD;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        x_end_nx    = x_end;
        y_end_nx    = y_end;
        cur_x_nx    = cur_x;
        cur_y_nx    = cur_y;
        row_base_nx = row_base;
        addr_nx     = addr_r;
        wdata_nx    = wdata_r;
        we_nx       = 1'b0;
        re_nx       = 1'b0;
        latch       = 1'b0;
        advance     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cmd_start) begin
                    latch    = 1'b1;
                    state_nx = SETUP;
                end
            end
            SETUP: begin
                x_end_nx    = (x_sum > HRES_W) ? HRES_W : x_sum;
                y_end_nx    = (y_sum > VRES_W) ? VRES_W : y_sum;
                cur_y_nx    = {1'b0, y_q};
                row_base_nx = (20'(y_q) << 8) + (20'(y_q) << 6);
                state_nx    = empty ? DONE : ROW;
            end
            ROW: begin
                cur_x_nx = {1'b0, x_q};
                state_nx = step_state(cur_x_nx, x_end);
            end
            FULL: begin
                we_nx    = 1'b1;
                addr_nx  = cur_addr;
                wdata_nx = {c_q, c_q};
                cur_x_nx = cur_x + 11'd2;
                advance  = 1'b1;
            end
            RD: begin
                re_nx    = 1'b1;
                addr_nx  = cur_addr;
                state_nx = RWAIT;
            end
            RWAIT: state_nx = MERGE;
            MERGE: begin
                we_nx    = 1'b1;
                addr_nx  = cur_addr;
                wdata_nx = cur_x[0] ? {bus.vmem_rdata[7:4], c_q} : {c_q, bus.vmem_rdata[3:0]};
                cur_x_nx = cur_x + 11'd1;
                advance  = 1'b1;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // The end-of-row step is folded into the byte that reaches x_end.
        if (advance) begin
            if (cur_x_nx == x_end) begin
                cur_y_nx    = cur_y + 10'd1;
                row_base_nx = row_base + BPL_W;
                state_nx    = (cur_y_nx == y_end) ? DONE : ROW;
            end else begin
                state_nx = step_state(cur_x_nx, x_end);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q      <= '0;
            y_q      <= '0;
            w_q      <= '0;
            h_q      <= '0;
            c_q      <= '0;
            x_end    <= '0;
            y_end    <= '0;
            cur_x    <= '0;
            cur_y    <= '0;
            row_base <= '0;
            addr_r   <= '0;
            wdata_r  <= '0;
            we_r     <= 1'b0;
            re_r     <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            if (latch) begin
                x_q <= bus.cmd_x;
                y_q <= bus.cmd_y;
                w_q <= bus.cmd_w;
                h_q <= bus.cmd_h;
                c_q <= bus.cmd_colour;
            end
            x_end    <= x_end_nx;
            y_end    <= y_end_nx;
            cur_x    <= cur_x_nx;
            cur_y    <= cur_y_nx;
            row_base <= row_base_nx;
            addr_r   <= addr_nx;
            wdata_r  <= wdata_nx;
            we_r     <= we_nx;
            re_r     <= re_nx;
            busy_r   <= (state_nx != IDLE) && (state_nx != DONE);
            done_r   <= (state_nx == DONE);
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.vmem_addr  = addr_r;
    assign bus.vmem_wdata = wdata_r;
    assign bus.vmem_we    = we_r;
    assign bus.vmem_re    = re_r;
endmodule

// File: tb/tb_vgafill.sv
// Bench for vgafill: a framebuffer memory with a synchronous read port, plus a nibble-level reference model.
// The bench runs a directed vector table, hand-written corner sequences and a random regression.
module tb_vgafill;
    localparam int MEM_SZ = 153600;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vgafill_if bus ();
    vgafill dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {logic [19:0] a; logic [7:0] d;} wr_t;

    logic [7:0] mem     [MEM_SZ];
    logic [7:0] ref_mem [MEM_SZ];
    wr_t        wr_log  [$];
    int         nrd_tot = 0, done_tot = 0, proto_err = 0;
    logic       fill_req = 1'b0, poke_req = 1'b0;
    int         fill_seed = 0, poke_addr = 0;
    logic [7:0] poke_dat = '0;
    int         checks = 0, errors = 0;

    function automatic logic [7:0] pattern(int seed, int i);
        if (seed == 0) return 8'h00;
        return 8'((i * 37) ^ (seed * 101) ^ (i >> 5));
    endfunction

    always @(posedge clk) begin
        if (fill_req) for (int i = 0; i < MEM_SZ; i++) mem[i] <= pattern(fill_seed, i);
        if (poke_req) mem[poke_addr] <= poke_dat;
        if (bus.vmem_re) begin
            nrd_tot <= nrd_tot + 1;
            if (int'(bus.vmem_addr) < MEM_SZ) bus.vmem_rdata <= mem[bus.vmem_addr];
        end
        if (bus.vmem_we) begin
            wr_log.push_back({bus.vmem_addr, bus.vmem_wdata});
            if (int'(bus.vmem_addr) < MEM_SZ) mem[bus.vmem_addr] <= bus.vmem_wdata;
        end
    end

    always @(negedge clk) begin
        if (bus.vmem_we && bus.vmem_re) proto_err <= proto_err + 1;
        else if (bus.done && bus.busy) proto_err <= proto_err + 1;
        else if ((bus.vmem_we || bus.vmem_re) && int'(bus.vmem_addr) >= MEM_SZ) proto_err <= proto_err + 1;
        if (bus.done) done_tot <= done_tot + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic do_fill(input int seed);
        fill_seed = seed;
        fill_req  = 1'b1;
        @(negedge clk);
        fill_req  = 1'b0;
        for (int i = 0; i < MEM_SZ; i++) ref_mem[i] = pattern(seed, i);
    endtask

    task automatic do_poke(input int a, input logic [7:0] d);
        poke_addr = a;
        poke_dat  = d;
        poke_req  = 1'b1;
        @(negedge clk);
        poke_req  = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic apply_ref(input int x, input int y, input int w, input int h, input int c);
        int xe, ye, a;
        xe = (x + w > 640) ? 640 : x + w;
        ye = (y + h > 480) ? 480 : y + h;
        for (int yy = y; yy < ye; yy++)
            for (int xx = x; xx < xe; xx++) begin
                a = yy * 320 + xx / 2;
                if (xx % 2 == 0) ref_mem[a][7:4] = 4'(c);
                else             ref_mem[a][3:0] = 4'(c);
            end
    endtask

    function automatic int calc_lat(input int x, input int y, input int w, input int h);
        int xe, ye, xa, per;
        if (w == 0 || h == 0 || x >= 640 || y >= 480) return 2;
        xe  = (x + w > 640) ? 640 : x + w;
        ye  = (y + h > 480) ? 480 : y + h;
        per = 1;
        xa  = x;
        if (x % 2 == 1) begin per += 3; xa = x + 1; end
        if (xa < xe) begin
            per += (xe - xa) / 2;
            if ((xe - xa) % 2 == 1) per += 3;
        end
        return 1 + (ye - y) * per + 1;
    endfunction

    task automatic mem_cmp(input string name);
        int bad;
        bad = -1;
        for (int i = 0; i < MEM_SZ; i++)
            if (bad < 0 && mem[i] !== ref_mem[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: byte %0d is 0x%0h, model wants 0x%0h", name, bad, mem[bad], ref_mem[bad]);
        end
    endtask

    // Issues one command from a negedge. Returns the cycle distance from the start strobe to done.
    // Returns with the last write already landed in memory.
    task automatic run_cmd(input int x, input int y, input int w, input int h, input int c, output int lat);
        bus.cmd_x      = 10'(x);
        bus.cmd_y      = 9'(y);
        bus.cmd_w      = 10'(w);
        bus.cmd_h      = 9'(h);
        bus.cmd_colour = 4'(c);
        bus.cmd_start  = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) bus.cmd_start = 1'b0;
        end while (!bus.done && lat < 5000);
        checks++;
        if (!bus.done) begin
            errors++;
            $display("FAIL cmd_timeout: no done after %0d cycles, required done", lat);
        end
        @(negedge clk);
    endtask

    typedef struct {
        int x, y, w, h, c, lat, nwr, nrd, a0, d0, a1, d1;
    } vec_t;
    vec_t vecs [11];

    initial begin
        int lat, wb, rb, db, rx, ry, rw, rh, rc;
        int exp_a [4];

        vecs[0]  = '{0,   0,   4,  2,  'hA, 8,  4, 0, 0,      'hAA, 321,    'hAA};
        vecs[1]  = '{1,   10,  2,  1,  5,   9,  2, 2, 3200,   'h35, 3201,   'h57};
        vecs[2]  = '{638, 479, 10, 10, 'hF, 4,  1, 0, 153599, 'hFF, 153599, 'hFF};
        vecs[3]  = '{5,   5,   0,  3,  1,   2,  0, 0, 0,      0,    0,      0};
        vecs[4]  = '{640, 0,   4,  4,  2,   2,  0, 0, 0,      0,    0,      0};
        vecs[5]  = '{0,   480, 4,  4,  2,   2,  0, 0, 0,      0,    0,      0};
        vecs[6]  = '{7,   7,   8,  0,  3,   2,  0, 0, 0,      0,    0,      0};
        vecs[7]  = '{639, 0,   1,  1,  3,   6,  1, 1, 319,    'h03, 319,    'h03};
        vecs[8]  = '{3,   2,   5,  1,  9,   8,  3, 1, 641,    'h09, 643,    'h99};
        vecs[9]  = '{2,   3,   3,  2,  6,   12, 4, 2, 961,    'h66, 1282,   'h60};
        vecs[10] = '{0,   0,   1,  1,  4,   6,  1, 1, 0,      'h4A, 0,      'h4A};

        bus.cmd_x = '0; bus.cmd_y = '0; bus.cmd_w = '0; bus.cmd_h = '0;
        bus.cmd_colour = '0; bus.cmd_start = 1'b0; bus.vmem_rdata = '0;

        @(negedge clk);
        do_fill(0);
        @(negedge clk);
        chk("rst_busy",  int'(bus.busy), 0);
        chk("rst_done",  int'(bus.done), 0);
        chk("rst_we",    int'(bus.vmem_we), 0);
        chk("rst_re",    int'(bus.vmem_re), 0);
        chk("rst_addr",  int'(bus.vmem_addr), 0);
        chk("rst_wdata", int'(bus.vmem_wdata), 0);
        rst = 1'b1;
        @(negedge clk);
        do_poke(3200, 8'h37);
        do_poke(3201, 8'h37);

        for (int i = 0; i < 11; i++) begin
            wb = wr_log.size();
            rb = nrd_tot;
            run_cmd(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].c, lat);
            apply_ref(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].c);
            chk($sformatf("v%0d_done_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_writes", i), wr_log.size() - wb, vecs[i].nwr);
            chk($sformatf("v%0d_reads", i), nrd_tot - rb, vecs[i].nrd);
            if (vecs[i].nwr > 0 && wr_log.size() - wb == vecs[i].nwr) begin
                chk($sformatf("v%0d_first_addr", i), int'(wr_log[wb].a), vecs[i].a0);
                chk($sformatf("v%0d_first_data", i), int'(wr_log[wb].d), vecs[i].d0);
                chk($sformatf("v%0d_last_addr", i),  int'(wr_log[wr_log.size()-1].a), vecs[i].a1);
                chk($sformatf("v%0d_last_data", i),  int'(wr_log[wr_log.size()-1].d), vecs[i].d1);
            end
            mem_cmp($sformatf("v%0d_memory", i));
        end

        // Aligned fill must write its bytes in scan order.
        exp_a = '{0, 1, 320, 321};
        wb = wr_log.size();
        run_cmd(0, 0, 4, 2, 'hC, lat);
        apply_ref(0, 0, 4, 2, 'hC);
        chk("order_count", wr_log.size() - wb, 4);
        for (int k = 0; k < 4; k++)
            if (wb + k < wr_log.size())
                chk($sformatf("order_addr%0d", k), int'(wr_log[wb + k].a), exp_a[k]);
        mem_cmp("order_memory");

        // Extra strobes while busy and in the DONE cycle must not disturb the clipped fill.
        wb = wr_log.size();
        db = done_tot;
        bus.cmd_x = 10'd638; bus.cmd_y = 9'd479; bus.cmd_w = 10'd10; bus.cmd_h = 9'd10;
        bus.cmd_colour = 4'hE; bus.cmd_start = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            bus.cmd_start = (lat == 1);
            if (lat == 1) begin
                bus.cmd_x = 10'd0; bus.cmd_y = 9'd0; bus.cmd_w = 10'd8; bus.cmd_h = 9'd8; bus.cmd_colour = 4'h1;
            end
        end while (!bus.done && lat < 100);
        chk("ignore_latency", lat, 4);
        bus.cmd_start = 1'b1;
        @(negedge clk);
        bus.cmd_start = 1'b0;
        repeat (10) @(negedge clk);
        apply_ref(638, 479, 10, 10, 'hE);
        chk("ignore_done_pulses", done_tot - db, 1);
        chk("ignore_writes", wr_log.size() - wb, 1);
        chk("ignore_busy_after", int'(bus.busy), 0);
        if (wr_log.size() - wb == 1) begin
            chk("ignore_addr", int'(wr_log[wb].a), 153599);
            chk("ignore_data", int'(wr_log[wb].d), 'hEE);
        end
        mem_cmp("ignore_memory");

        // Reset lands in the middle of a run of full-byte writes.
        bus.cmd_x = 10'd0; bus.cmd_y = 9'd20; bus.cmd_w = 10'd64; bus.cmd_h = 9'd4;
        bus.cmd_colour = 4'h1; bus.cmd_start = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            bus.cmd_start = 1'b0;
        end while (!bus.vmem_we && lat < 50);
        chk("rstmid_saw_write", int'(bus.vmem_we), 1);
        rst = 1'b0;
        #1;
        chk("rstmid_we",    int'(bus.vmem_we), 0);
        chk("rstmid_busy",  int'(bus.busy), 0);
        chk("rstmid_re",    int'(bus.vmem_re), 0);
        chk("rstmid_addr",  int'(bus.vmem_addr), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wb = wr_log.size();
        rb = nrd_tot;
        db = done_tot;
        repeat (30) @(negedge clk);
        chk("rstmid_writes_after", wr_log.size() - wb, 0);
        chk("rstmid_reads_after", nrd_tot - rb, 0);
        chk("rstmid_done_after", done_tot - db, 0);
        chk("rstmid_busy_after", int'(bus.busy), 0);

        do_fill(7);
        @(negedge clk);
        for (int n = 0; n < 200; n++) begin
            rx = $urandom_range(0, 650);
            ry = $urandom_range(0, 490);
            rw = $urandom_range(0, 24);
            rh = $urandom_range(0, 6);
            rc = $urandom_range(0, 15);
            run_cmd(rx, ry, rw, rh, rc, lat);
            apply_ref(rx, ry, rw, rh, rc);
            chk($sformatf("rand%0d_latency(x=%0d y=%0d w=%0d h=%0d)", n, rx, ry, rw, rh), lat, calc_lat(rx, ry, rw, rh));
            mem_cmp($sformatf("rand%0d_memory", n));
        end

        chk("protocol_violations", proto_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vgafill.md
# vgafill

Rectangle-fill engine on the write side of the 640x480 4-bit greyscale framebuffer. The display scanner reads this framebuffer, and this engine sits directly upstream of it. It accepts a fill command (origin, size, grey level) from the CPU register block and writes the packed pixel bytes through the video-memory write port. Partially covered bytes at rectangle edges are handled by read-modify-write. Everything runs in the 100 MHz system clock domain.

## Interface
Parameters:
- HRES, 640, framebuffer width in pixels (must be even)
- VRES, 480, framebuffer height in lines
- BPL, 320, bytes per line (HRES/2)

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-low reset
- cmd_x  in  10  left pixel column
- cmd_y  in  9  top line
- cmd_w  in  10  width in pixels
- cmd_h  in  9  height in lines
- cmd_colour  in  4  grey level
- cmd_start  in  1  one-cycle start strobe; cmd_* sampled on this cycle
- busy  out  1  high while a command executes
- done  out  1  one-cycle pulse when a command completes
- vmem_addr  out  20  byte address, shared by read and write
- vmem_re  out  1  read strobe
- vmem_rdata  in  8  read data, valid the cycle after vmem_re
- vmem_we  out  1  write strobe
- vmem_wdata  out  8  write data

## Operation
- Packing:
  - byte address = y*BPL + (x>>1).
  - Even x uses bits [7:4]; odd x uses bits [3:0]. The even pixel is the first one scanned out.
- Clip at SETUP:
  - x_end = min(cmd_x+cmd_w, HRES); y_end = min(cmd_y+cmd_h, VRES). Use 11-bit/10-bit sums so there is no overflow.
  - Empty command if cmd_w==0, cmd_h==0, cmd_x>=HRES or cmd_y>=VRES. An empty command goes straight to DONE and issues no memory accesses.
- Row base: computed once as (y<<8)+(y<<6), then +BPL per row. No multiplier.
- FSM states: IDLE, SETUP, ROW, FULL, RD, RWAIT, MERGE, DONE.
  - IDLE: a cmd_start strobe latches cmd_* and moves to SETUP.
  - SETUP: clip; initialise row base and cur_y = cmd_y. Next state is ROW, or DONE if empty.
  - ROW: set cur_x = cmd_x. Next state is FULL if cur_x is even and x_end-cur_x>=2, otherwise RD.
  - FULL: write {c,c} with vmem_we=1 and cur_x += 2. Choose the next state by the same rule as ROW; at x==x_end, go to end-of-row.
  - RD: vmem_re=1 at the current byte address.
  - RWAIT: wait one cycle for vmem_rdata.
  - MERGE: replace the nibble selected by cur_x[0] with c, keep the other nibble from vmem_rdata, and write with vmem_we=1. Then cur_x += 1.
  - End-of-row: cur_y += 1 and row base += BPL. Next state is ROW, or DONE when cur_y==y_end.
  - DONE: done=1 for one cycle, then IDLE.
- cmd_start while busy or in DONE: ignored, with no effect on the running command.
- Only pixels in [cmd_x,x_end) × [cmd_y,y_end) are modified. The neighbouring nibble in an edge byte keeps its previous value.

## Timing
- Reset (asynchronous) forces:
  - state IDLE;
  - busy, done, vmem_we, vmem_re = 0;
  - vmem_addr = 0, vmem_wdata = 0.
  - An in-flight command is abandoned; no partial write is issued after rst deasserts.
- busy rises the cycle after cmd_start and falls in the DONE cycle; done and busy are never high together.
- vmem_we and vmem_re are registered outputs and are never asserted in the same cycle. Address and data are stable in the strobe cycle.
- Cost per row:
  - ROW: 1 cycle.
  - Each full byte: 1 cycle.
  - Each edge byte: 3 cycles (RD, RWAIT, MERGE).
  - End-of-row: folded into the final FULL or MERGE cycle.
- Empty command: start, SETUP, DONE. done pulses 2 cycles after the start strobe.
- Address wrap: the last byte is 153599. Addresses never exceed VRES*BPL-1.

## Test plan
- Reset mid-command:
  - Stimulus: assert rst during FULL.
  - Response: vmem_we=0 and busy=0 in the same cycle. After release, state is IDLE and no writes occur until the next start.
- Aligned fill (x=0, y=0, w=4, h=2, c=0xA):
  - Writes 0xAA to addresses 0, 1, 320, 321 in that order. No reads.
  - done pulse 8 cycles after start.
- Unaligned fill (x=1, y=10, w=2, h=1, c=5), memory preset to 0x37 at 3200 and 3201:
  - Reads address 3200, writes 0x35.
  - Reads address 3201, writes 0x57.
- Clipped fill (x=638, y=479, w=10, h=10, c=0xF):
  - Exactly one write, 0xFF to address 153599.
  - Start strobes issued while busy are ignored; there is exactly one done pulse.
- Empty commands (w=0; then x=640):
  - No vmem_re or vmem_we.
  - done 2 cycles after each start.
- Random regression:
  - 200 random commands checked against a 153600-byte reference model.
  - After each done, the whole memory matches the model, with untouched nibbles preserved.
